// File: rtl/cache_pkg.sv
// Shared types and field widths for the direct-mapped cache controller.
// The optional CACHE_CTRL_STATS_EN feature is handled in the top level, not here.
package cache_pkg;

    localparam int ADDR_WIDTH   = 10;
    localparam int DATA_WIDTH   = 32;
    localparam int TAG_WIDTH    = 3;
    localparam int INDEX_WIDTH  = 5;
    localparam int OFFSET_WIDTH = 2;
    localparam int LINE_WORDS   = 4;
    localparam int LINE_WIDTH   = LINE_WORDS * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FILL  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Main-memory word address of one beat of a line refill.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(
        input logic [TAG_WIDTH-1:0]    tag,
        input logic [INDEX_WIDTH-1:0]  index,
        input logic [OFFSET_WIDTH-1:0] beat
    );
        return {tag, index, beat};
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache-array and main-memory signals of the cache controller.
// master: the controller side; slave: the CPU/array/memory environment.
interface cache_controller_if;
    import cache_pkg::*;

    logic                    cpu_read;
    logic                    cpu_write;
    logic [ADDR_WIDTH-1:0]   cpu_addr;
    logic [DATA_WIDTH-1:0]   cpu_wdata;
    logic                    cpu_stall;

    logic                    c_hit;
    logic [TAG_WIDTH-1:0]    c_tag;
    logic [INDEX_WIDTH-1:0]  c_index;
    logic [OFFSET_WIDTH-1:0] c_offset;
    logic                    c_re;
    logic                    c_refill;
    logic                    c_update;
    logic [LINE_WIDTH-1:0]   c_line_data;
    logic [DATA_WIDTH-1:0]   c_write_data;

    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ready;

    modport master (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, c_hit, mem_rdata, mem_ready,
        output cpu_stall, c_tag, c_index, c_offset, c_re, c_refill, c_update,
               c_line_data, c_write_data, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, c_hit, mem_rdata, mem_ready,
        input  cpu_stall, c_tag, c_index, c_offset, c_re, c_refill, c_update,
               c_line_data, c_write_data, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/line_fill_buffer.sv
// Beat counter and line assembly register for read-miss refills.
// The counter wraps after the last beat, so every fetch starts at beat 0.
module line_fill_buffer
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    capture,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic [OFFSET_WIDTH-1:0] beat,
    output logic                    last_beat,
    output logic [LINE_WIDTH-1:0]   line
);

    logic [OFFSET_WIDTH-1:0] beat_r;
    logic [DATA_WIDTH-1:0]   words_r [LINE_WORDS];

    // Beat counter and word capture on each completed memory beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_r <= '0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                words_r[k] <= '0;
            end
        end else if (clear) begin
            beat_r <= '0;
        end else if (capture) begin
            words_r[beat_r] <= rdata;
            beat_r          <= beat_r + 2'd1;
        end
    end

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_line
        assign line[k*DATA_WIDTH +: DATA_WIDTH] = words_r[k];
    end

    assign beat      = beat_r;
    assign last_beat = (beat_r == OFFSET_WIDTH'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through / no-write-allocate cache control FSM.
// Define CACHE_CTRL_STATS_EN to add saturating hit_count / miss_count outputs.
module cache_controller
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    cache_controller_if.master bus
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]        hit_count,
    output logic [31:0]        miss_count
`endif
);

    state_t                  state_r;
    state_t                  state_next;
    logic                    fill_start;
    logic                    fill_capture;
    logic [OFFSET_WIDTH-1:0] beat;
    logic                    last_beat;

    assign bus.c_tag        = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign bus.c_index      = bus.cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign bus.c_offset     = bus.cpu_addr[OFFSET_WIDTH-1:0];
    assign bus.c_re         = bus.cpu_read;
    assign bus.c_write_data = bus.cpu_wdata;
    assign fill_capture     = (state_r == FETCH) && bus.mem_ready;

    line_fill_buffer u_fill (
        .clk       (clk),
        .rst       (reset),
        .clear     (fill_start),
        .capture   (fill_capture),
        .rdata     (bus.mem_rdata),
        .beat      (beat),
        .last_beat (last_beat),
        .line      (bus.c_line_data)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and output decode; a simultaneous read and write is a write.
    always_comb begin
        state_next    = state_r;
        bus.cpu_stall = 1'b0;
        bus.c_refill  = 1'b0;
        bus.c_update  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        fill_start    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.cpu_write) begin
                    bus.cpu_stall = 1'b1;
                    bus.c_update  = bus.c_hit;
                    state_next    = WRITE;
                end else if (bus.cpu_read && !bus.c_hit) begin
                    bus.cpu_stall = 1'b1;
                    fill_start    = 1'b1;
                    state_next    = FETCH;
                end else begin
                    bus.cpu_stall = 1'b0;
                end
            end
            FETCH: begin
                bus.cpu_stall = 1'b1;
                bus.mem_read  = 1'b1;
                bus.mem_addr  = beat_addr(bus.c_tag, bus.c_index, beat);
                if (bus.mem_ready && last_beat) begin
                    state_next = FILL;
                end else begin
                    state_next = FETCH;
                end
            end
            FILL: begin
                bus.cpu_stall = 1'b1;
                bus.c_refill  = 1'b1;
                state_next    = IDLE;
            end
            WRITE: begin
                bus.cpu_stall = 1'b1;
                bus.mem_write = 1'b1;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
                if (bus.mem_ready) begin
                    state_next = DONE;
                end else begin
                    state_next = WRITE;
                end
            end
            DONE: begin
                bus.cpu_stall = 1'b0;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic from_fill_r;
    logic count_hit;
    logic count_miss;

    // The hit right after a refill retires an already-counted miss.
    assign count_hit  = (state_r == IDLE) && bus.cpu_read && !bus.cpu_write &&
                        bus.c_hit && !from_fill_r;
    assign count_miss = (state_r == IDLE) && bus.cpu_read && !bus.cpu_write && !bus.c_hit;

    // Saturating read statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count   <= 32'd0;
            miss_count  <= 32'd0;
            from_fill_r <= 1'b0;
        end else begin
            from_fill_r <= (state_r == FILL);
            if (count_hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (count_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller; memory word[a] = a*3.
// Build with CACHE_CTRL_STATS_EN defined to also exercise the statistics counters.
module tb_cache_controller;

    logic clk;
    logic rst;
    cache_controller_if bus ();

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_controller dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Memory responder: ready after wait_cycles low cycles of a pending request.
    int wait_cycles = 0;
    int wait_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (!(bus.mem_read || bus.mem_write) || bus.mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign bus.mem_ready = (bus.mem_read || bus.mem_write) && (wait_cnt >= wait_cycles);
    assign bus.mem_rdata = 32'(bus.mem_addr) * 32'd3;

    int             refills, updates, overlap, write_n, read_cycles, unstable;
    logic [9:0]     fetch_q [$];
    logic [9:0]     wr_addr, prev_addr;
    logic [31:0]    wr_data;
    logic [127:0]   line_cap;
    bit             prev_pend;

    task automatic clear_logs();
        refills = 0; updates = 0; overlap = 0; write_n = 0; read_cycles = 0; unstable = 0;
        fetch_q.delete(); prev_pend = 1'b0; prev_addr = '0; wr_addr = '0; wr_data = '0;
        line_cap = '0;
    endtask

    task automatic sample_cycle();
        bit pend;
        pend = bus.mem_read || bus.mem_write;
        if (bus.c_refill) begin refills++; line_cap = bus.c_line_data; end
        if (bus.c_update) updates++;
        if (bus.c_refill && bus.c_update) overlap++;
        if (prev_pend && (!pend || bus.mem_addr !== prev_addr)) unstable++;
        if (bus.mem_read) read_cycles++;
        if (bus.mem_read && bus.mem_ready) fetch_q.push_back(bus.mem_addr);
        if (bus.mem_write && bus.mem_ready) begin
            write_n++; wr_addr = bus.mem_addr; wr_data = bus.mem_wdata;
        end
        prev_pend = pend && !bus.mem_ready;
        prev_addr = bus.mem_addr;
    endtask

    // Presents one CPU access at a negedge and runs it until stall drops.
    task automatic do_access(input logic rd, input logic wr, input logic [9:0] addr,
                             input logic [31:0] wdata, input logic hit,
                             output int stall_cycles, output bit timeout);
        clear_logs();
        bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_addr = addr;
        bus.cpu_wdata = wdata; bus.c_hit = hit;
        stall_cycles = 0; timeout = 1'b0;
        forever begin
            #1;
            sample_cycle();
            if (!bus.cpu_stall) break;
            stall_cycles++;
            if (stall_cycles > 200) begin timeout = 1'b1; break; end
            @(negedge clk);
            if (refills > 0) bus.c_hit = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.c_hit = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        compared++; if (bus.cpu_stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got %b want 0", bus.cpu_stall); end
        compared++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin mismatched++; $display("FAIL reset_mem_req got %b want 00", {bus.mem_read, bus.mem_write}); end
        compared++; if (bus.mem_addr !== 10'h000) begin mismatched++; $display("FAIL reset_mem_addr got %h want 000", bus.mem_addr); end
        compared++; if ({bus.c_refill, bus.c_update} !== 2'b00) begin mismatched++; $display("FAIL reset_strobes got %b want 00", {bus.c_refill, bus.c_update}); end
        compared++; if (bus.c_line_data !== 128'h0) begin mismatched++; $display("FAIL reset_line got %h want 0", bus.c_line_data); end
`ifdef CACHE_CTRL_STATS_EN
        compared++; if ({hit_count, miss_count} !== 64'h0) begin mismatched++; $display("FAIL reset_stats got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
        @(negedge clk);
    endtask

    task automatic test_fields();
        bus.cpu_addr = 10'h045; bus.cpu_wdata = 32'hCAFE_F00D; bus.cpu_read = 1'b0;
        #1;
        compared++; if ({bus.c_tag, bus.c_index, bus.c_offset} !== {3'd0, 5'h11, 2'd1}) begin mismatched++; $display("FAIL fields_045 got %h/%h/%h want 0/11/1", bus.c_tag, bus.c_index, bus.c_offset); end
        compared++; if (bus.c_write_data !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL write_data got %h want cafef00d", bus.c_write_data); end
        compared++; if (bus.c_re !== 1'b0) begin mismatched++; $display("FAIL c_re_low got %b want 0", bus.c_re); end
        bus.cpu_addr = 10'h3FF;
        #1;
        compared++; if ({bus.c_tag, bus.c_index, bus.c_offset} !== {3'd7, 5'h1F, 2'd3}) begin mismatched++; $display("FAIL fields_3ff got %h/%h/%h want 7/1f/3", bus.c_tag, bus.c_index, bus.c_offset); end
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        int sc; bit to;
        wait_cycles = 0;
        do_access(1'b1, 1'b0, 10'h044, 32'h0, 1'b0, sc, to);
        compared++; if (to) begin mismatched++; $display("FAIL miss_timeout got stall>200 want done"); end
        compared++; if (sc !== 6) begin mismatched++; $display("FAIL miss_stall_cycles got %0d want 6", sc); end
        compared++; if (fetch_q.size() !== 4) begin mismatched++; $display("FAIL miss_beats got %0d want 4", fetch_q.size()); end
        for (int i = 0; i < 4 && i < fetch_q.size(); i++) begin
            compared++; if (fetch_q[i] !== 10'h044 + 10'(i)) begin mismatched++; $display("FAIL miss_addr%0d got %h want %h", i, fetch_q[i], 10'h044 + 10'(i)); end
        end
        compared++; if (refills !== 1) begin mismatched++; $display("FAIL miss_refills got %0d want 1", refills); end
        compared++; if (line_cap !== {32'hD5, 32'hD2, 32'hCF, 32'hCC}) begin mismatched++; $display("FAIL miss_line got %h want d5/d2/cf/cc", line_cap); end
        compared++; if (updates !== 0) begin mismatched++; $display("FAIL miss_updates got %0d want 0", updates); end
    endtask

    task automatic test_read_hit();
        int sc; bit to;
        do_access(1'b1, 1'b0, 10'h046, 32'h0, 1'b1, sc, to);
        compared++; if (sc !== 0) begin mismatched++; $display("FAIL hit_stall_cycles got %0d want 0", sc); end
        compared++; if (read_cycles !== 0) begin mismatched++; $display("FAIL hit_mem_read got %0d want 0", read_cycles); end
        compared++; if (refills !== 0) begin mismatched++; $display("FAIL hit_refills got %0d want 0", refills); end
`ifdef CACHE_CTRL_STATS_EN
        compared++; if (miss_count !== 32'd1) begin mismatched++; $display("FAIL stats_miss got %0d want 1", miss_count); end
        compared++; if (hit_count !== 32'd1) begin mismatched++; $display("FAIL stats_hit got %0d want 1", hit_count); end
`endif
    endtask

    task automatic test_write_hit();
        int sc; bit to;
        do_access(1'b0, 1'b1, 10'h045, 32'hDEAD_BEEF, 1'b1, sc, to);
        compared++; if (updates !== 1) begin mismatched++; $display("FAIL wh_updates got %0d want 1", updates); end
        compared++; if (write_n !== 1) begin mismatched++; $display("FAIL wh_writes got %0d want 1", write_n); end
        compared++; if ({wr_addr, wr_data} !== {10'h045, 32'hDEAD_BEEF}) begin mismatched++; $display("FAIL wh_mem got %h:%h want 045:deadbeef", wr_addr, wr_data); end
        compared++; if (sc !== 2) begin mismatched++; $display("FAIL wh_stall_cycles got %0d want 2", sc); end
        compared++; if (overlap !== 0) begin mismatched++; $display("FAIL wh_overlap got %0d want 0", overlap); end
    endtask

    task automatic test_write_miss();
        int sc; bit to;
        do_access(1'b0, 1'b1, 10'h3FF, 32'h1234_5678, 1'b0, sc, to);
        compared++; if ({updates, refills} !== {32'd0, 32'd0}) begin mismatched++; $display("FAIL wm_strobes got %0d/%0d want 0/0", updates, refills); end
        compared++; if (write_n !== 1) begin mismatched++; $display("FAIL wm_writes got %0d want 1", write_n); end
        compared++; if ({wr_addr, wr_data} !== {10'h3FF, 32'h1234_5678}) begin mismatched++; $display("FAIL wm_mem got %h:%h want 3ff:12345678", wr_addr, wr_data); end
        compared++; if (sc !== 2) begin mismatched++; $display("FAIL wm_stall_cycles got %0d want 2", sc); end
    endtask

    task automatic test_slow_memory();
        int sc; bit to;
        wait_cycles = 5;
        do_access(1'b1, 1'b0, 10'h0A0, 32'h0, 1'b0, sc, to);
        wait_cycles = 0;
        compared++; if (sc !== 26) begin mismatched++; $display("FAIL slow_stall_cycles got %0d want 26", sc); end
        compared++; if (unstable !== 0) begin mismatched++; $display("FAIL slow_addr_stable got %0d changes want 0", unstable); end
        compared++; if (fetch_q.size() !== 4) begin mismatched++; $display("FAIL slow_beats got %0d want 4", fetch_q.size()); end
        compared++; if (line_cap !== {32'h1E9, 32'h1E6, 32'h1E3, 32'h1E0}) begin mismatched++; $display("FAIL slow_line got %h want 1e9/1e6/1e3/1e0", line_cap); end
    endtask

    task automatic test_reset_mid_fetch();
        int sc; bit to; int n;
        clear_logs();
        bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 10'h100; bus.c_hit = 1'b0;
        n = 0;
        forever begin
            #1;
            sample_cycle();
            if (fetch_q.size() >= 2 || n > 50) break;
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        compared++; if ({bus.mem_read, bus.mem_addr} !== {1'b1, 10'h102}) begin mismatched++; $display("FAIL rst_beat2 got %b:%h want 1:102", bus.mem_read, bus.mem_addr); end
        rst = 1'b1;
        bus.cpu_read = 1'b0;
        clear_logs();
        @(negedge clk);
        #1;
        sample_cycle();
        compared++; if (bus.mem_read !== 1'b0) begin mismatched++; $display("FAIL rst_mem_read got %b want 0", bus.mem_read); end
        compared++; if (refills !== 0) begin mismatched++; $display("FAIL rst_refill got %0d want 0", refills); end
        rst = 1'b0;
        @(negedge clk);
        do_access(1'b1, 1'b0, 10'h100, 32'h0, 1'b0, sc, to);
        compared++; if (fetch_q.size() !== 4) begin mismatched++; $display("FAIL refetch_beats got %0d want 4", fetch_q.size()); end
        compared++; if (sc !== 6) begin mismatched++; $display("FAIL refetch_stall got %0d want 6", sc); end
        compared++; if (line_cap !== {32'h309, 32'h306, 32'h303, 32'h300}) begin mismatched++; $display("FAIL refetch_line got %h want 309/306/303/300", line_cap); end
    endtask

    initial begin
        test_reset();
        test_fields();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_write_miss();
        test_slow_memory();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
